led_sprite_ctrl: RTL

Sequencer that shares one pair of 1024×16 RGB565 sprite ROMs (LED-on and LED-off images, 32×32 px, synchronous read) among a horizontal row of LED indicators on the VGA raster. It tracks the current pixel coordinate and generates ROM address and enable for the sprite under the beam. It selects the on/off image per LED from a frame-latched state vector and returns a pipelined pixel with a transparency flag to the video mixer.

---
 rtl/led_sprite_ctrl_pkg.sv | 21 ++
 rtl/led_sprite_ctrl_if.sv | 23 ++
 rtl/led_sprite_ctrl_pix_pipe.sv | 51 +++++
 rtl/led_sprite_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/led_sprite_ctrl_pkg.sv
// Shared constants, FSM state type and colour helper for the LED sprite sequencer.
package led_pkg;

  localparam int SPRITE_W = 32;
  localparam int SPRITE_H = 32;
  localparam int ROM_LAT  = 1;

  localparam logic [15:0] TRANSPARENT = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_opaque(input logic [15:0] colour);
    return colour != TRANSPARENT;
  endfunction

endpackage

// File: rtl/led_sprite_ctrl_if.sv
// Port bundle between the sequencer and the shared on/off sprite ROM pair.
interface led_sprite_ctrl_if;

  logic [9:0]  rom_ad;
  logic        rom_ce;
  logic [15:0] rom_dout_on;
  logic [15:0] rom_dout_off;

  modport master (
    output rom_ad,
    output rom_ce,
    input  rom_dout_on,
    input  rom_dout_off
  );

  modport slave (
    input  rom_ad,
    input  rom_ce,
    output rom_dout_on,
    output rom_dout_off
  );

endinterface

// File: rtl/led_sprite_ctrl_pix_pipe.sv
// Delays valid/select across the ROM read, then muxes on/off data and masks transparent pixels.
module led_pix_pipe
  import led_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        v_i,
  input  logic        sel_i,
  input  logic [15:0] dout_on_i,
  input  logic [15:0] dout_off_i,
  output logic [15:0] pix_o,
  output logic        pix_valid_o
);

  logic [ROM_LAT-1:0] vdly_q;
  logic [ROM_LAT-1:0] sdly_q;
  logic [15:0]        data_s;
  logic               opaque_s;
  logic [15:0]        pix_q;
  logic               pix_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vdly_q <= '0;
      sdly_q <= '0;
    end else begin
      vdly_q <= ROM_LAT'({vdly_q, v_i});
      sdly_q <= ROM_LAT'({sdly_q, sel_i});
    end
  end

  always_comb begin
    data_s   = sdly_q[ROM_LAT-1] ? dout_on_i : dout_off_i;
    opaque_s = vdly_q[ROM_LAT-1] && is_opaque(data_s);
  end

  // Non-opaque output is forced to zero so the mixer can ignore pix when invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q       <= 16'h0000;
      pix_valid_q <= 1'b0;
    end else begin
      pix_q       <= opaque_s ? data_s : 16'h0000;
      pix_valid_q <= opaque_s;
    end
  end

  assign pix_o       = pix_q;
  assign pix_valid_o = pix_valid_q;

endmodule

// File: rtl/led_sprite_ctrl.sv
// Raster sequencer for a row of LED sprites sharing one on/off ROM pair; 3-cycle pixel latency.
module led_sprite_ctrl
  import led_pkg::*;
#(
  parameter int NUM_LEDS = 8,
  parameter int X0       = 64,
  parameter int Y0       = 224,
  parameter int PITCH    = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  de,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  frame_start,
  input  logic [NUM_LEDS-1:0]   leds,
  led_sprite_ctrl_if.master     rom,
  output logic [15:0]           pix,
  output logic                  pix_valid
);

  localparam logic [9:0]  X0_V     = 10'(X0);
  localparam logic [10:0] Y0_V     = 11'(Y0);
  localparam logic [10:0] Y_END    = 11'(Y0 + SPRITE_H);
  localparam logic [4:0]  LAST_COL = 5'(SPRITE_W - 1);
  localparam logic [3:0]  LAST_IDX = 4'(NUM_LEDS - 1);
  localparam logic [9:0]  GAP_LAST = 10'(PITCH - 33);

  state_e              state_q, state_d;
  logic [4:0]          col_q, col_d;
  logic [3:0]          idx_q, idx_d;
  logic [9:0]          gap_q, gap_d;
  logic [NUM_LEDS-1:0] leds_q;
  logic [9:0]          rom_ad_q;
  logic                rom_ce_q;
  logic                sel1_q;

  logic                band_s;
  logic                start_s;
  logic                draw_s;
  logic [4:0]          cur_col_s;
  logic [3:0]          cur_idx_s;
  logic [4:0]          row_s;
  logic [15:0]         leds_ext_s;

  assign band_s     = ({1'b0, y} >= Y0_V) && ({1'b0, y} < Y_END);
  assign start_s    = band_s && (x == X0_V);
  assign row_s      = 5'(y - 10'(Y0));
  assign leds_ext_s = 16'(leds_q);

  // The entry pixel at x == X0 is emitted from IDLE so the address appears one cycle after its coordinate.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    draw_s    = 1'b0;
    cur_col_s = col_q;
    cur_idx_s = idx_q;
    if (!de) begin
      state_d = IDLE;
      col_d   = 5'd0;
      idx_d   = 4'd0;
      gap_d   = 10'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_s) begin
            draw_s    = 1'b1;
            cur_col_s = 5'd0;
            cur_idx_s = 4'd0;
            state_d   = DRAW;
            col_d     = 5'd1;
            idx_d     = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end
        DRAW: begin
          draw_s = 1'b1;
          if (col_q == LAST_COL) begin
            col_d = 5'd0;
            gap_d = 10'd0;
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              state_d = GAP;
            end
          end else begin
            col_d = col_q + 5'd1;
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = DRAW;
            idx_d   = idx_q + 4'd1;
            col_d   = 5'd0;
          end else begin
            gap_d = gap_q + 10'd1;
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= 5'd0;
      idx_q   <= 4'd0;
      gap_q   <= 10'd0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  // LED states are captured once per frame so a sprite never changes image mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_q <= '0;
    end else if (frame_start) begin
      leds_q <= leds;
    end else begin
      leds_q <= leds_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_ad_q <= 10'd0;
      rom_ce_q <= 1'b0;
      sel1_q   <= 1'b0;
    end else if (draw_s) begin
      rom_ad_q <= {row_s, cur_col_s};
      rom_ce_q <= 1'b1;
      sel1_q   <= leds_ext_s[cur_idx_s];
    end else begin
      rom_ce_q <= 1'b0;
    end
  end

  assign rom.rom_ad = rom_ad_q;
  assign rom.rom_ce = rom_ce_q;

  led_pix_pipe u_pix_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .v_i         (rom_ce_q),
    .sel_i       (sel1_q),
    .dout_on_i   (rom.rom_dout_on),
    .dout_off_i  (rom.rom_dout_off),
    .pix_o       (pix),
    .pix_valid_o (pix_valid)
  );

endmodule
